// File: rtl/bsg_counter_overflow_ctrl_if.sv
// ---------------------------------------------------------------------------
// bsg_counter_overflow_ctrl_if
//
// Purpose:
//   Bundles the configuration, run-control, count and overflow-event signals
//   of bsg_counter_overflow_ctrl so they travel as a single port. Signal names
//   keep their _i/_o suffixes as seen from the controller, so the slave side
//   reads exactly like the controller's own port list.
//
// Parameters:
//   width_p       counter, init and limit width in bits
//   miss_width_p  width of the saturating missed-event counter
//
// Signals (direction as seen by the controller / slave modport):
//   cfg_v_i         in   config valid
//   cfg_init_i      in   reload/start value
//   cfg_max_i       in   overflow value (terminal count)
//   cfg_periodic_i  in   1 = reload and continue, 0 = one-shot
//   cfg_ready_o     out  config accepted when cfg_v_i & cfg_ready_o
//   start_i         in   start or resume counting
//   stop_i          in   pause (RUN) or abort (ARMED/DONE)
//   en_i            in   count-enable tick, only looked at while running
//   count_o         out  registered current count
//   busy_o          out  high while running
//   event_v_o       out  overflow event pending
//   event_yumi_i    in   consumer takes the pending event
//   missed_o        out  overflows lost while an event was pending
//
// Modports:
//   master  the side that configures/controls the counter and consumes events
//   slave   the counter controller itself
// ---------------------------------------------------------------------------
interface bsg_counter_overflow_ctrl_if #(
   parameter int width_p      = 31,
   parameter int miss_width_p = 8
);

   logic                    cfg_v_i;
   logic [width_p-1:0]      cfg_init_i;
   logic [width_p-1:0]      cfg_max_i;
   logic                    cfg_periodic_i;
   logic                    cfg_ready_o;

   logic                    start_i;
   logic                    stop_i;
   logic                    en_i;

   logic [width_p-1:0]      count_o;
   logic                    busy_o;

   logic                    event_v_o;
   logic                    event_yumi_i;
   logic [miss_width_p-1:0] missed_o;

   // Controller-facing view: takes config/control/yumi, presents status.
   modport slave (
      input  cfg_v_i,
      input  cfg_init_i,
      input  cfg_max_i,
      input  cfg_periodic_i,
      output cfg_ready_o,
      input  start_i,
      input  stop_i,
      input  en_i,
      output count_o,
      output busy_o,
      output event_v_o,
      input  event_yumi_i,
      output missed_o
   );

   // Software/upstream-FSM view: drives config/control/yumi, observes status.
   modport master (
      output cfg_v_i,
      output cfg_init_i,
      output cfg_max_i,
      output cfg_periodic_i,
      input  cfg_ready_o,
      output start_i,
      output stop_i,
      output en_i,
      input  count_o,
      input  busy_o,
      input  event_v_o,
      output event_yumi_i,
      input  missed_o
   );

endinterface

// File: rtl/bsg_counter_overflow_ctrl.sv
// ---------------------------------------------------------------------------
// bsg_counter_overflow_ctrl
//
// Purpose:
//   Run-control front end for an up-counter that reloads on overflow.
//   A producer loads init/limit/periodic values, then starts, pauses and
//   aborts the count. Every overflow is offered as a valid/yumi event; any
//   overflow that happens while an earlier event is still pending (and not
//   being taken in that same cycle) is counted in a saturating miss counter.
//   Typical use: programmable periodic or one-shot ticks (timeouts, refresh).
//
// Parameters:
//   width_p       counter, init and limit width in bits
//   miss_width_p  width of the saturating missed-event counter
//
// Ports:
//   clk_i    in  clock; every state update happens on its rising edge
//   reset_i  in  asynchronous, active-high reset
//   bus      slave modport of bsg_counter_overflow_ctrl_if carrying config,
//            start/stop/enable, count/busy status and the overflow event
//
// States:
//   IDLE   nothing configured (or aborted); start is ignored
//   ARMED  configured or paused; start resumes from the held count
//   RUN    counting on en_i; config is refused here
//   DONE   one-shot reached its limit; start reloads init and runs again
//
// Every output is a flop, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module bsg_counter_overflow_ctrl #(
   parameter int width_p      = 31,
   parameter int miss_width_p = 8
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   bsg_counter_overflow_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [width_p-1:0]      count_one = width_p'(1);
   localparam logic [miss_width_p-1:0] miss_one  = miss_width_p'(1);

   state_e                  state;
   logic [width_p-1:0]      count;
   logic [width_p-1:0]      init_val;
   logic [width_p-1:0]      max_val;
   logic                    periodic;
   logic                    busy;
   logic                    cfg_ready;
   logic                    event_v;
   logic [miss_width_p-1:0] missed;

   logic                    accept;
   logic                    at_max;
   logic                    overflow;
   logic                    miss_full;

   // cfg_ready is a registered decode of "not RUN", so accepting config never
   // depends combinationally on cfg_v_i itself. An overflow needs a running
   // counter sitting on its limit with en_i high and no stop_i in the same
   // cycle (stop_i wins over en_i). Config is never accepted in RUN, but it is
   // kept in the term so the priority order stays explicit.
   assign accept    = bus.cfg_v_i & cfg_ready;
   assign at_max    = (count == max_val);
   assign overflow  = (state == RUN) & ~accept & ~bus.stop_i & bus.en_i & at_max;
   assign miss_full = &missed;

   // Controller FSM together with its registered outputs. Config accept has
   // top priority in every state, then stop_i, then start_i, then en_i.
   // busy and cfg_ready are updated alongside every state change so they are
   // always a one-flop decode of the state being entered. The event/miss
   // bookkeeping lives in the same block so one clock edge moves everything
   // together: an accepted config wipes any stale event, an overflow raises
   // (or keeps) the event, and a yumi without a fresh overflow clears it.
   // A yumi that lands on the same edge as a new overflow is consumed by the
   // old event while the new one takes its place, so nothing is missed then.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state     <= IDLE;
         count     <= '0;
         init_val  <= '0;
         max_val   <= '0;
         periodic  <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b1;
         event_v   <= 1'b0;
         missed    <= '0;
      end else begin
         if (accept) begin
            init_val  <= bus.cfg_init_i;
            max_val   <= bus.cfg_max_i;
            periodic  <= bus.cfg_periodic_i;
            count     <= bus.cfg_init_i;
            state     <= ARMED;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end

               ARMED: begin
                  if (bus.stop_i) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     cfg_ready <= 1'b1;
                  end else if (bus.start_i) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     cfg_ready <= 1'b0;
                  end
               end

               RUN: begin
                  if (bus.stop_i) begin
                     state     <= ARMED;
                     busy      <= 1'b0;
                     cfg_ready <= 1'b1;
                  end else if (bus.en_i) begin
                     if (at_max) begin
                        if (periodic) begin
                           count <= init_val;
                        end else begin
                           state     <= DONE;
                           busy      <= 1'b0;
                           cfg_ready <= 1'b1;
                        end
                     end else begin
                        count <= count + count_one;
                     end
                  end
               end

               DONE: begin
                  if (bus.stop_i) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     cfg_ready <= 1'b1;
                  end else if (bus.start_i) begin
                     count     <= init_val;
                     state     <= RUN;
                     busy      <= 1'b1;
                     cfg_ready <= 1'b0;
                  end
               end

               default: begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
               end
            endcase
         end

         if (accept) begin
            event_v <= 1'b0;
            missed  <= '0;
         end else if (overflow) begin
            event_v <= 1'b1;
            if (event_v & ~bus.event_yumi_i & ~miss_full) begin
               missed <= missed + miss_one;
            end
         end else if (bus.event_yumi_i) begin
            event_v <= 1'b0;
         end
      end
   end

   // Status outputs are straight flop outputs.
   assign bus.count_o     = count;
   assign bus.busy_o      = busy;
   assign bus.cfg_ready_o = cfg_ready;
   assign bus.event_v_o   = event_v;
   assign bus.missed_o    = missed;

endmodule

// File: tb/tb_bsg_counter_overflow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bsg_counter_overflow_ctrl
//
// Purpose:
//   Self-checking bench for bsg_counter_overflow_ctrl. The stimulus process
//   steps a behavioural model of the counter once per cycle and queues the
//   status the DUT should show after that clock edge; a monitor on the
//   falling edge pops and compares. Directed scenarios cover periodic and
//   one-shot runs, pause/abort, miss saturation, same-cycle yumi/overflow,
//   wrap through zero and asynchronous reset, followed by a random phase.
// ---------------------------------------------------------------------------
module tb_bsg_counter_overflow_ctrl;

   localparam int     W        = 31;
   localparam int     MW       = 8;
   localparam longint MOD      = longint'(1) << W;
   localparam int     MISS_MAX = (1 << MW) - 1;

   typedef enum int {M_IDLE, M_ARMED, M_RUN, M_DONE} mode_t;

   typedef struct {
      longint count;
      bit     busy;
      bit     ev;
      int     missed;
      bit     ready;
      string  tag;
   } exp_t;

   logic clk_i = 1'b0;
   logic reset_i;

   bsg_counter_overflow_ctrl_if #(.width_p(W), .miss_width_p(MW)) bus ();

   bsg_counter_overflow_ctrl #(.width_p(W), .miss_width_p(MW)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   exp_t   expQ[$];
   int     nCompared   = 0;
   int     nMismatched = 0;

   // Behavioural model state.
   mode_t  mMode;
   longint mCount, mInit, mMax;
   bit     mPer, mEv;
   int     mMissed;

   function automatic exp_t snap(string tag);
      exp_t e;
      e.count  = mCount;
      e.busy   = (mMode == M_RUN);
      e.ev     = mEv;
      e.missed = mMissed;
      e.ready  = (mMode != M_RUN);
      e.tag    = tag;
      return e;
   endfunction

   task automatic modelReset();
      mMode   = M_IDLE;
      mCount  = 0;
      mInit   = 0;
      mMax    = 0;
      mPer    = 0;
      mEv     = 0;
      mMissed = 0;
   endtask

   // One clock edge of the counter described from its rules.
   task automatic modelStep(bit cfgV, longint init, longint max, bit per,
                            bit start, bit stop, bit en, bit yumi);
      bit ovf;
      ovf = 0;
      if (cfgV && mMode != M_RUN) begin
         mInit   = init;
         mMax    = max;
         mPer    = per;
         mCount  = init;
         mMode   = M_ARMED;
         mEv     = 0;
         mMissed = 0;
      end else begin
         case (mMode)
            M_ARMED: if (stop) mMode = M_IDLE; else if (start) mMode = M_RUN;
            M_RUN: begin
               if (stop) mMode = M_ARMED;
               else if (en) begin
                  if (mCount == mMax) begin
                     ovf = 1;
                     if (mPer) mCount = mInit;
                     else mMode = M_DONE;
                  end else begin
                     mCount = (mCount + 1) % MOD;
                  end
               end
            end
            M_DONE: begin
               if (stop) mMode = M_IDLE;
               else if (start) begin
                  mCount = mInit;
                  mMode  = M_RUN;
               end
            end
            default: ;
         endcase
         if (ovf) begin
            if (mEv && !yumi && mMissed < MISS_MAX) mMissed = mMissed + 1;
            mEv = 1;
         end else if (yumi) begin
            mEv = 0;
         end
      end
   endtask

   task automatic checkOutput(exp_t e);
      nCompared++;
      if (longint'(bus.count_o) != e.count || bus.busy_o !== e.busy ||
          bus.event_v_o !== e.ev || int'(bus.missed_o) != e.missed ||
          bus.cfg_ready_o !== e.ready) begin
         nMismatched++;
         $display("[TB] FAIL %s: got count=%0d busy=%0b ev=%0b missed=%0d ready=%0b, want count=%0d busy=%0b ev=%0b missed=%0d ready=%0b",
                  e.tag, bus.count_o, bus.busy_o, bus.event_v_o, bus.missed_o, bus.cfg_ready_o,
                  e.count, e.busy, e.ev, e.missed, e.ready);
      end
   endtask

   // Drive one cycle of inputs, predict the post-edge status, then clock.
   task automatic applyStimulus(string tag, bit cfgV, longint init, longint max, bit per,
                                bit start, bit stop, bit en, bit yumi);
      bus.cfg_v_i        = cfgV;
      bus.cfg_init_i     = W'(init);
      bus.cfg_max_i      = W'(max);
      bus.cfg_periodic_i = per;
      bus.start_i        = start;
      bus.stop_i         = stop;
      bus.en_i           = en;
      bus.event_yumi_i   = yumi;
      modelStep(cfgV, init, max, per, start, stop, en, yumi);
      expQ.push_back(snap(tag));
      @(posedge clk_i);
      #1;
   endtask

   task automatic cyc(string tag, bit start, bit stop, bit en, bit yumi);
      applyStimulus(tag, 1'b0, 0, 0, 1'b0, start, stop, en, yumi);
   endtask

   task automatic cfg(string tag, longint init, longint max, bit per);
      applyStimulus(tag, 1'b1, init, max, per, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset between clock edges and check that it acts before the next edge.
   task automatic midCycleReset(string tag);
      @(negedge clk_i);
      #1;
      reset_i = 1'b1;
      bus.cfg_v_i = 0; bus.start_i = 0; bus.stop_i = 0; bus.en_i = 0; bus.event_yumi_i = 0;
      #1;
      modelReset();
      checkOutput(snap(tag));
      #1;
      reset_i = 1'b0;
   endtask

   // Monitor: compare each queued expectation once the DUT has settled.
   always @(negedge clk_i) begin
      if (!reset_i && expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   initial begin
      reset_i = 1'b1;
      bus.cfg_v_i = 0; bus.cfg_init_i = '0; bus.cfg_max_i = '0; bus.cfg_periodic_i = 0;
      bus.start_i = 0; bus.stop_i = 0; bus.en_i = 0; bus.event_yumi_i = 0;
      modelReset();
      #3;
      checkOutput(snap("reset"));
      #1;
      reset_i = 1'b0;

      // Start is ignored while idle.
      cyc("idle_start", 1, 0, 1, 0);

      // Periodic 5..7 with every event taken.
      cfg("t1_cfg", 5, 7, 1);
      cyc("t1_start", 1, 0, 0, 0);
      for (int i = 0; i < 12; i++) cyc("t1_run", 0, 0, 1, mEv);

      // Config refused while running; then one-shot 0..3 and restart.
      applyStimulus("cfg_in_run", 1'b1, 9, 9, 1'b0, 1'b0, 1'b0, 1'b1, mEv);
      cyc("t2_stop", 0, 1, 0, mEv);
      cfg("t2_cfg", 0, 3, 0);
      cyc("t2_start", 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc("t2_run", 0, 0, 1, mEv);
      cyc("t2_restart", 1, 0, 1, 0);
      for (int i = 0; i < 2; i++) cyc("t2_run2", 0, 0, 1, 0);

      // Overflow every tick, never taken: miss counter saturates.
      cyc("t3_stop", 0, 1, 0, 0);
      cfg("t3_cfg", 0, 0, 1);
      cyc("t3_start", 1, 0, 0, 0);
      for (int i = 0; i < 262; i++) cyc("t3_run", 0, 0, 1, 0);

      // Pause, resume, abort.
      cyc("t4_stop", 0, 1, 0, 0);
      cfg("t4_cfg", 0, 100, 1);
      cyc("t4_start", 1, 0, 0, 0);
      cyc("t4_en", 0, 0, 1, 0);
      cyc("t4_en", 0, 0, 1, 0);
      cyc("t4_pause", 0, 1, 1, 0);
      cyc("t4_resume", 1, 0, 1, 0);
      cyc("t4_en", 0, 0, 1, 0);
      cyc("t4_stop1", 0, 1, 0, 0);
      cyc("t4_stop2", 0, 1, 0, 0);

      // Yumi coinciding with a new overflow, then a clearing yumi.
      cfg("t5_cfg", 0, 1, 1);
      cyc("t5_start", 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) cyc("t5_first", 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc("t5_same", 0, 0, 1, mEv && (mCount == mMax));
      cyc("t5_clear", 0, 0, 0, mEv);

      // Init above max: wraps through zero before overflowing.
      cyc("wrap_stop", 0, 1, 0, 0);
      cfg("wrap_cfg", MOD - 2, 1, 1);
      cyc("wrap_start", 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc("wrap_run", 0, 0, 1, mEv);

      // Asynchronous reset with count 10 and an event pending.
      cyc("t6_stop", 0, 1, 0, 0);
      cfg("t6_cfg", 10, 10, 1);
      cyc("t6_start", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc("t6_run", 0, 0, 1, 0);
      midCycleReset("t6_async_reset");

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bit     cv, st, sp, en, yu, pr;
         longint ini, mx;
         int     sel;
         cv  = ($urandom_range(0, 7) == 0);
         st  = ($urandom_range(0, 3) == 0);
         sp  = ($urandom_range(0, 9) == 0);
         en  = ($urandom_range(0, 3) != 0);
         yu  = mEv && ($urandom_range(0, 1) == 1);
         pr  = ($urandom_range(0, 2) != 0);
         sel = $urandom_range(0, 3);
         case (sel)
            0: begin ini = $urandom_range(0, 7); mx = $urandom_range(0, 7); end
            1: begin ini = MOD - 1 - $urandom_range(0, 5); mx = $urandom_range(0, 5); end
            2: begin ini = longint'($urandom) % MOD; mx = longint'($urandom) % MOD; end
            default: begin ini = $urandom_range(0, 3); mx = $urandom_range(0, 12); end
         endcase
         applyStimulus("random", cv, ini, mx, pr, st, sp, en, yu);
      end

      @(negedge clk_i);
      #1;
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
